// File: rtl/router_pkg.sv
// Shared types and helpers for the N-master by M-slave request router.
package router_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slave_state_t;

  // Width of the per-slave round-robin pointer debug field (up to 16 masters).
  localparam int PTR_W = 4;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner when en is high.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = (N > 1) ? clog2_f(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] gnt_idx;
  logic          found;

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/router_nxm.sv
// N-master to M-slave request router with one IDLE/BUSY/DONE engine per slave.
// Optional watchdog on stuck slaves is enabled with the ROUTER_TIMEOUT_EN macro.
module router_nxm
  import router_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_MASTERS-1:0]                 m_req,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]                 m_we,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]                 m_ack,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]                 m_err,
  output logic [NUM_SLAVES-1:0]                  s_req,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  s_addr,
  output logic [NUM_SLAVES-1:0]                  s_we,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_wdata,
  input  logic [NUM_SLAVES-1:0]                  s_ack,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_rdata,
  output logic [NUM_SLAVES-1:0][1:0]             slave_state,
  output logic [NUM_SLAVES-1:0][PTR_W-1:0]       rr_ptr
);

  // Handshake: a master holds m_req and its fields until a one-cycle m_ack;
  // a slave sees s_req held for the whole BUSY phase and answers with s_ack.
  localparam int SW = clog2_f(NUM_SLAVES);
  localparam int PW = (NUM_MASTERS > 1) ? clog2_f(NUM_MASTERS) : 1;

  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] done_owner;
  logic [NUM_SLAVES-1:0]                  done_err;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  done_rdata;

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    slave_state_t            state;
    logic [NUM_MASTERS-1:0]  hit;
    logic [NUM_MASTERS-1:0]  gnt;
    logic [NUM_MASTERS-1:0]  owner;
    logic [PW-1:0]           arb_ptr;
    logic [ADDR_WIDTH-1:0]   sel_addr, addr_q;
    logic                    sel_we, we_q;
    logic [DATA_WIDTH-1:0]   sel_wdata, wdata_q, rdata_q;
    logic                    req_q, ack_q;
`ifdef ROUTER_TIMEOUT_EN
    localparam int TW = clog2_f(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           busy_cnt;
    logic                    err_q;
`endif

    always_comb begin
      hit       = '0;
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        hit[m] = m_req[m] && (m_addr[m][ADDR_WIDTH-1 -: SW] == SW'(s));
        if (gnt[m]) begin
          sel_addr  = m_addr[m];
          sel_we    = m_we[m];
          sel_wdata = m_wdata[m];
        end
      end
    end

    // Only IDLE consults the arbiter, so a request still high in DONE waits a cycle.
    rr_arbiter #(.N(NUM_MASTERS), .PW(PW)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (hit),
      .en  (state == S_IDLE),
      .gnt (gnt),
      .ptr (arb_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= S_IDLE;
        owner   <= '0;
        addr_q  <= '0;
        we_q    <= 1'b0;
        wdata_q <= '0;
        rdata_q <= '0;
        req_q   <= 1'b0;
        ack_q   <= 1'b0;
`ifdef ROUTER_TIMEOUT_EN
        busy_cnt <= '0;
        err_q    <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (|hit) begin
              state   <= S_BUSY;
              owner   <= gnt;
              addr_q  <= sel_addr;
              we_q    <= sel_we;
              wdata_q <= sel_wdata;
              req_q   <= 1'b1;
`ifdef ROUTER_TIMEOUT_EN
              busy_cnt <= '0;
`endif
            end
          end
          S_BUSY: begin
            if (s_ack[s]) begin
              state   <= S_DONE;
              req_q   <= 1'b0;
              ack_q   <= 1'b1;
              rdata_q <= s_rdata[s];
            end
`ifdef ROUTER_TIMEOUT_EN
            else if (busy_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state   <= S_DONE;
              req_q   <= 1'b0;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
`endif
          end
          S_DONE: begin
            state   <= S_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
`ifdef ROUTER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign s_req[s]       = req_q;
    assign s_addr[s]      = addr_q;
    assign s_we[s]        = we_q;
    assign s_wdata[s]     = wdata_q;
    assign slave_state[s] = state;
    assign rr_ptr[s]      = PTR_W'(arb_ptr);
    assign done_owner[s]  = ack_q ? owner : '0;
    assign done_rdata[s]  = rdata_q;
`ifdef ROUTER_TIMEOUT_EN
    assign done_err[s]    = err_q;
`else
    assign done_err[s]    = 1'b0;
`endif
  end

  always_comb begin
    m_ack   = '0;
    m_err   = '0;
    m_rdata = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (done_owner[s][m]) begin
          m_ack[m]   = 1'b1;
          m_err[m]   = m_err[m] | done_err[s];
          m_rdata[m] = m_rdata[m] | done_rdata[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_router_nxm.sv
// Directed self-checking bench for router_nxm (4 masters, 4 slaves, 32-bit buses).
module tb_router_nxm;

  logic              clk;
  logic              rst;
  logic [3:0]        m_req;
  logic [3:0][31:0]  m_addr;
  logic [3:0]        m_we;
  logic [3:0][31:0]  m_wdata;
  logic [3:0]        m_ack;
  logic [3:0][31:0]  m_rdata;
  logic [3:0]        m_err;
  logic [3:0]        s_req;
  logic [3:0][31:0]  s_addr;
  logic [3:0]        s_we;
  logic [3:0][31:0]  s_wdata;
  logic [3:0]        s_ack;
  logic [3:0][31:0]  s_rdata;
  logic [3:0][1:0]   slave_state;
  logic [3:0][3:0]   rr_ptr;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  router_nxm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_MASTERS(4), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .slave_state(slave_state), .rr_ptr(rr_ptr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_master(input int m, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata);
    m_addr[m]  = addr;
    m_we[m]    = we;
    m_wdata[m] = wdata;
    m_req[m]   = 1'b1;
  endtask

  initial begin
    int         first_ack;
    logic       saw_ack;
    logic       found;
    logic [3:0] exp_m;

    rst     = 1'b0;
    m_req   = '0;
    m_addr  = '0;
    m_we    = '0;
    m_wdata = '0;
    s_ack   = '0;
    s_rdata = '0;
    repeat (3) tick();
    check_eq("reset_s_req", 64'(s_req), 64'h0);
    check_eq("reset_m_ack", 64'(m_ack), 64'h0);
    check_eq("reset_state", 64'(slave_state), 64'h0);
    rst = 1'b1;
    tick();

    // Write from m0 to slave 1; master fields change while pending
    drive_master(0, 32'h4000_0010, 1'b1, 32'hA5A5_A5A5);
    tick();
    check_eq("wr_s_req", 64'(s_req), 64'b0010);
    check_eq("wr_s_addr", 64'(s_addr[1]), 64'h4000_0010);
    check_eq("wr_s_we", 64'(s_we[1]), 64'h1);
    check_eq("wr_s_wdata", 64'(s_wdata[1]), 64'hA5A5_A5A5);
    m_addr[0]  = 32'h7FFF_FFFC;
    m_wdata[0] = 32'h0000_0000;
    tick();
    check_eq("wr_hold_addr", 64'(s_addr[1]), 64'h4000_0010);
    check_eq("wr_hold_wdata", 64'(s_wdata[1]), 64'hA5A5_A5A5);
    tick();
    s_ack[1] = 1'b1;
    check_eq("wr_no_early_ack", 64'(m_ack), 64'h0);
    tick();
    check_eq("wr_m_ack", 64'(m_ack), 64'b0001);
    check_eq("wr_s_req_done", 64'(s_req), 64'h0);
    check_eq("wr_m_err", 64'(m_err), 64'h0);
    s_ack   = '0;
    m_req   = '0;
    tick();
    check_eq("wr_ack_pulse", 64'(m_ack), 64'h0);

    // A stray s_ack to an idle slave is ignored
    s_ack[1] = 1'b1;
    tick();
    s_ack = '0;
    check_eq("idle_ack_ignored", 64'(m_ack), 64'h0);
    check_eq("idle_ack_state", 64'(slave_state[1]), 64'(0));

    // Read from m2 to slave 3
    drive_master(2, 32'hC000_0000, 1'b0, 32'h0);
    tick();
    check_eq("rd_s_req", 64'(s_req), 64'b1000);
    check_eq("rd_s_we", 64'(s_we[3]), 64'h0);
    s_ack[3]   = 1'b1;
    s_rdata[3] = 32'hDEAD_BEEF;
    tick();
    check_eq("rd_m_ack", 64'(m_ack), 64'b0100);
    check_eq("rd_m_rdata", 64'(m_rdata[2]), 64'hDEAD_BEEF);
    check_eq("rd_m_err", 64'(m_err), 64'h0);
    check_eq("rd_other_rdata", 64'(m_rdata[0]), 64'h0);
    s_ack = '0;
    m_req = '0;
    tick();

    // Parallel: m0 -> s0 and m1 -> s3 in the same cycle
    drive_master(0, 32'h0000_0100, 1'b0, 32'h0);
    drive_master(1, 32'hC000_0004, 1'b0, 32'h0);
    tick();
    check_eq("par_s_req", 64'(s_req), 64'b1001);
    s_ack      = 4'b1001;
    s_rdata[0] = 32'h1111_1111;
    s_rdata[3] = 32'h3333_3333;
    tick();
    check_eq("par_m_ack", 64'(m_ack), 64'b0011);
    check_eq("par_rdata0", 64'(m_rdata[0]), 64'h1111_1111);
    check_eq("par_rdata1", 64'(m_rdata[1]), 64'h3333_3333);
    s_ack = '0;
    m_req = '0;
    tick();

    // Contention on slave 2: round-robin grant order from a fresh pointer
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    for (int m = 0; m < 4; m++) drive_master(m, 32'h8000_0000 + 32'(m * 4), 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        if (s_req[2]) found = 1'b1;
        else tick();
      end
      check_eq("rr_s_req_seen", 64'(found), 64'h1);
      tick();
      s_ack[2]   = 1'b1;
      s_rdata[2] = 32'hA0 + 32'(k);
      tick();
      s_ack = '0;
      exp_m = exp_q.pop_front();
      check_eq("rr_grant", 64'(m_ack), 64'(4'b0001 << exp_m));
      check_eq("rr_rdata", 64'(m_rdata[exp_m]), 64'hA0 + 64'(k));
      if (k == 4) m_req = '0;
      tick();
      check_eq("rr_no_regrant_in_done", 64'(s_req[2]), 64'h0);
    end
    tick();

    // Watchdog: slave 1 never answers
    drive_master(0, 32'h4000_0020, 1'b0, 32'h0);
    tick();
    check_eq("to_s_req", 64'(s_req), 64'b0010);
    first_ack = 0;
    saw_ack   = 1'b0;
`ifdef ROUTER_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (m_ack[0] && !saw_ack) begin
        saw_ack   = 1'b1;
        first_ack = i;
        check_eq("to_m_err", 64'(m_err[0]), 64'h1);
        check_eq("to_m_rdata", 64'(m_rdata[0]), 64'h0);
        check_eq("to_s_req_off", 64'(s_req[1]), 64'h0);
        m_req[0] = 1'b0;
      end
    end
    check_eq("to_ack_cycle", 64'(first_ack), 64'd16);
`else
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (m_ack[0]) saw_ack = 1'b1;
    end
    check_eq("no_to_no_ack", 64'(saw_ack), 64'h0);
    check_eq("no_to_still_busy", 64'(s_req[1]), 64'h1);
`endif
    m_req[0] = 1'b0;
    tick();

    // Asynchronous reset in the middle of a BUSY transaction
    drive_master(1, 32'h8000_0040, 1'b0, 32'h0);
    tick();
    check_eq("rst_pre_s_req2", 64'(s_req[2]), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_s_req", 64'(s_req), 64'h0);
    check_eq("rst_m_ack", 64'(m_ack), 64'h0);
    check_eq("rst_rr_ptr", 64'(rr_ptr), 64'h0);
    check_eq("rst_state", 64'(slave_state), 64'h0);
    m_req = '0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_no_stale_ack", 64'(m_ack), 64'h0);
    drive_master(3, 32'h8000_0080, 1'b0, 32'h0);
    tick();
    check_eq("post_rst_s_req", 64'(s_req), 64'b0100);
    check_eq("post_rst_s_addr", 64'(s_addr[2]), 64'h8000_0080);
    s_ack[2]   = 1'b1;
    s_rdata[2] = 32'h5A5A_0003;
    tick();
    s_ack = '0;
    check_eq("post_rst_m_ack", 64'(m_ack), 64'b1000);
    check_eq("post_rst_rdata", 64'(m_rdata[3]), 64'h5A5A_0003);
    m_req = '0;
    tick();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_nxm.md
ROUTER_NXM -- requirements
Module: router_nxm

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 Parameter NUM_MASTERS, default 4, master port count; legal range 1..16.
REQ-004 Parameter NUM_SLAVES, default 4, slave port count; power of two, legal range 2..16.
REQ-005 Parameter TIMEOUT_CYCLES, default 16, watchdog limit; used only with ROUTER_TIMEOUT_EN.
REQ-006 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-007 Port rst, input, 1, asynchronous active-low reset.
REQ-008 Port m_req, input, [NUM_MASTERS], per-master request; held until m_ack.
REQ-009 Port m_addr, input, [NUM_MASTERS][ADDR_WIDTH], per-master address.
REQ-010 Port m_we, input, [NUM_MASTERS], 1 = write, 0 = read.
REQ-011 Port m_wdata, input, [NUM_MASTERS][DATA_WIDTH], per-master write data.
REQ-012 Port m_ack, output, [NUM_MASTERS], one-cycle completion pulse.
REQ-013 Port m_rdata, output, [NUM_MASTERS][DATA_WIDTH], read data; valid with m_ack.
REQ-014 Port m_err, output, [NUM_MASTERS], error flag; valid with m_ack.
REQ-015 Port s_req, output, [NUM_SLAVES], per-slave request.
REQ-016 Port s_addr, s_we, s_wdata, outputs, [NUM_SLAVES] x ADDR_WIDTH/1/DATA_WIDTH, forwarded master fields.
REQ-017 Port s_ack, input, [NUM_SLAVES], slave completion.
REQ-018 Port s_rdata, input, [NUM_SLAVES][DATA_WIDTH], slave read data; valid with s_ack.

Function
REQ-019 Target slave index SHALL be m_addr[ADDR_WIDTH-1 -: log2(NUM_SLAVES)]; the full address SHALL be forwarded unmodified.
REQ-020 Each slave port SHALL have an independent FSM with states IDLE, BUSY and DONE.
REQ-021 IDLE->BUSY: any request targets this slave; the arbiter grant SHALL be registered together with the granted master's addr/we/wdata.
REQ-022 BUSY SHALL drive s_req=1 with the latched fields; BUSY->DONE on s_ack=1.
REQ-023 DONE SHALL last exactly one cycle, pulse m_ack of the granted master with m_rdata=s_rdata captured at s_ack, drive s_req=0, and return to IDLE.
REQ-024 Latency: m_req seen at edge 0, s_req at edge 1; s_ack at edge k gives m_ack at edge k+1.
REQ-025 Arbitration SHALL be round-robin per slave: priority starts at (last granted + 1) mod NUM_MASTERS, and the pointer updates only on grant.
REQ-026 Transactions to different slaves SHALL proceed concurrently with no cross-slave stall.
REQ-027 An m_req still high in DONE SHALL NOT be regranted in that cycle; it competes again from IDLE.
REQ-028 s_ack outside BUSY SHALL be ignored.
REQ-029 A master changing addr/data while its request is pending SHALL not affect the latched transaction.
REQ-030 Non-granted m_ack, m_err and m_rdata SHALL be 0.

Reset
REQ-031 rst low SHALL immediately force all FSMs to IDLE, all outputs to 0 and all RR pointers to 0, including mid-BUSY; the aborted transaction SHALL receive no m_ack.

Configuration
REQ-032 With ROUTER_TIMEOUT_EN defined, a per-slave counter SHALL count BUSY cycles; on reaching TIMEOUT_CYCLES the FSM SHALL go to DONE with m_err=1, m_rdata=0 and s_req=0.
REQ-033 Without ROUTER_TIMEOUT_EN there SHALL be no counter, m_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-034 Package router_pkg SHALL hold the slave FSM state enum and the log2 width-helper function.
REQ-035 Sub-module rr_arbiter (NUM_MASTERS requests in, one-hot grant out, pointer update on enable) SHALL be instantiated once per slave.

Verification
REQ-036 Write: m0 addr 0x4000_0010, wdata 0xA5A5A5A5, we=1 -> s_req[1] at edge 1 with identical fields; s_ack at edge 3 -> m_ack[0] at edge 4 only.
REQ-037 Read: m2 to 0xC000_0000; s3 returns s_rdata 0xDEADBEEF with s_ack -> m_rdata[2]=0xDEADBEEF with m_ack[2], m_err=0.
REQ-038 Contention: m0..m3 all hold requests to slave 2, and slave acks each after 1 cycle -> grant order 0,1,2,3,0, with no master granted twice in a row.
REQ-039 Parallel: m0->s0 and m1->s3 in the same cycle -> s_req[0] and s_req[3] both at edge 1.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=16): slave never acks -> m_ack=1 and m_err=1 exactly 16 BUSY cycles after grant; macro off -> no m_ack after 100 cycles.
REQ-041 Reset mid-BUSY: rst low asynchronously -> s_req, m_ack and pointers are 0 before the next edge; after release, a fresh request from m3 completes normally.
